uart_program_loader: RTL and testbench



---
 rtl/uart_program_loader.sv | 195 +++++++++++++++++++
 tb/tb_uart_program_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// UART-fed loader for the core's instruction RAM: decodes 8N1 bytes, parses
// HDR/count/data/checksum frames and emits one-cycle write strobes.
module uart_program_loader #(
  parameter int                    CLKS_PER_BIT = 16,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] HDR_BYTE     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  load_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]         HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]         IDX_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] DEPTH_B   = DATA_WIDTH'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {F_IDLE, F_COUNT, F_DATA, F_CSUM} fr_state_t;

  function automatic logic [DATA_WIDTH-1:0] csum_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  rx_state_t               rx_state_r;
  fr_state_t               fr_state_r;
  logic                    sync1_r, sync2_r, rx_d_r;
  logic [CW-1:0]           cnt_r;
  logic [BW-1:0]           bit_idx_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [DATA_WIDTH-1:0]   rx_byte_r;
  logic                    byte_valid_r;
  logic                    frame_err_r;
  logic [IW-1:0]           n_r;
  logic [IW-1:0]           idx_r;
  logic [DATA_WIDTH-1:0]   sum_r;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      rx_d_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      rx_d_r  <= sync2_r;
    end
  end

  // UART receiver: mid-bit sampling, registered byte_valid / framing-error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r   <= R_IDLE;
      cnt_r        <= {CW{1'b0}};
      bit_idx_r    <= {BW{1'b0}};
      shift_r      <= {DATA_WIDTH{1'b0}};
      rx_byte_r    <= {DATA_WIDTH{1'b0}};
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        R_IDLE: begin
          if (rx_d_r && !sync2_r) begin
            cnt_r      <= {CW{1'b0}};
            rx_state_r <= R_START;
          end
        end
        R_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r      <= {CW{1'b0}};
            bit_idx_r  <= {BW{1'b0}};
            rx_state_r <= sync2_r ? R_IDLE : R_DATA;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        R_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= {CW{1'b0}};
            shift_r <= {sync2_r, shift_r[DATA_WIDTH-1:1]};
            if (bit_idx_r == IDX_LAST) begin
              rx_state_r <= R_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + {{(BW-1){1'b0}}, 1'b1};
            end
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        R_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r      <= {CW{1'b0}};
            rx_state_r <= R_IDLE;
            if (sync2_r) begin
              byte_valid_r <= 1'b1;
              rx_byte_r    <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: rx_state_r <= R_IDLE;
      endcase
    end
  end

  // Frame parser: load_en gate has priority, then framing abort, then byte handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fr_state_r <= F_IDLE;
      n_r        <= {IW{1'b0}};
      idx_r      <= {IW{1'b0}};
      sum_r      <= {DATA_WIDTH{1'b0}};
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_WIDTH{1'b0}};
      mem_wdata  <= {DATA_WIDTH{1'b0}};
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (!load_en) begin
        fr_state_r <= F_IDLE;
        cpu_hold   <= 1'b0;
      end else if (frame_err_r) begin
        if (fr_state_r != F_IDLE) begin
          err        <= 1'b1;
          cpu_hold   <= 1'b0;
          fr_state_r <= F_IDLE;
        end
      end else if (byte_valid_r) begin
        case (fr_state_r)
          F_IDLE: begin
            if (rx_byte_r == HDR_BYTE) begin
              err        <= 1'b0;
              sum_r      <= {DATA_WIDTH{1'b0}};
              idx_r      <= {IW{1'b0}};
              cpu_hold   <= 1'b1;
              fr_state_r <= F_COUNT;
            end
          end
          F_COUNT: begin
            if (rx_byte_r == {DATA_WIDTH{1'b0}} || rx_byte_r > DEPTH_B) begin
              err        <= 1'b1;
              cpu_hold   <= 1'b0;
              fr_state_r <= F_IDLE;
            end else begin
              n_r        <= rx_byte_r[IW-1:0];
              fr_state_r <= F_DATA;
            end
          end
          F_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= idx_r[ADDR_WIDTH-1:0];
            mem_wdata <= rx_byte_r;
            sum_r     <= csum_add(sum_r, rx_byte_r);
            idx_r     <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            if (idx_r + {{(IW-1){1'b0}}, 1'b1} == n_r) begin
              fr_state_r <= F_CSUM;
            end
          end
          F_CSUM: begin
            if (rx_byte_r == sum_r) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            cpu_hold   <= 1'b0;
            fr_state_r <= F_IDLE;
          end
          default: fr_state_r <= F_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: serial frames in, RAM writes scoreboarded.
module tb_uart_program_loader;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       load_en;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [11:0] exp_q [$];
  logic [7:0]  payload [$];

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (4),
    .DATA_WIDTH  (8),
    .HDR_BYTE    (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .load_en  (load_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(4);
  endtask

  // Sends header, count, payload and checksum (xor'd with bad), queueing expected writes.
  task automatic send_frame(input logic [7:0] bad);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(8'hA5, 1'b1);
    check("hold_after_hdr", 32'(cpu_hold), 32'd1);
    send_byte(8'(payload.size()), 1'b1);
    for (int i = 0; i < payload.size(); i++) begin
      exp_q.push_back({4'(i), payload[i]});
      sum = sum + payload[i];
      send_byte(payload[i], 1'b1);
    end
    check("hold_before_csum", 32'(cpu_hold), 32'd1);
    send_byte(sum ^ bad, 1'b1);
  endtask

  // Scoreboard and done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL wr_unexpected: observed addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({mem_addr, mem_wdata} === e) else begin
          errors++;
          $error("FAIL wr_addr_data: observed %0h expected %0h", {mem_addr, mem_wdata}, e);
        end
      end
      checks++;
      assert (cpu_hold === 1'b1) else begin
        errors++;
        $error("FAIL wr_hold: observed %0b expected 1", cpu_hold);
      end
    end
    if (!rst && done) begin
      done_cnt++;
      checks++;
      assert ({err, cpu_hold} === 2'b00) else begin
        errors++;
        $error("FAIL done_cycle: observed err/hold %0b expected 00", {err, cpu_hold});
      end
    end
  end

  initial begin
    rst     = 1'b0;
    rx      = 1'b1;
    load_en = 1'b1;
    #2 rst  = 1'b1;
    tick(3);
    check("reset_outputs", 32'({mem_we, mem_addr, mem_wdata, cpu_hold, done, err}), 32'd0);
    rst = 1'b0;
    tick(5);

    // Reference frame: 41 8A C7, checksum 92.
    payload = '{8'h41, 8'h8A, 8'hC7};
    send_frame(8'h00);
    tick(5);
    check("f1_done", 32'(done_cnt), 32'd1);
    check("f1_err", 32'(err), 32'd0);
    check("f1_hold", 32'(cpu_hold), 32'd0);
    check("f1_q", 32'(exp_q.size()), 32'd0);

    // Bad checksum 93.
    send_frame(8'h01);
    tick(20);
    check("bad_csum_done", 32'(done_cnt), 32'd1);
    check("bad_csum_err", 32'(err), 32'd1);
    check("bad_csum_q", 32'(exp_q.size()), 32'd0);
    send_byte(8'hA5, 1'b1);
    check("hdr_clears_err", 32'(err), 32'd0);
    send_byte(8'h02, 1'b1);
    exp_q.push_back(12'h010);
    send_byte(8'h10, 1'b1);
    exp_q.push_back(12'h120);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b1);
    tick(3);
    check("recover_done", 32'(done_cnt), 32'd2);

    // Count 0 and count 17 rejected; trailing byte ignored.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    check("cnt0_err", 32'(err), 32'd1);
    check("cnt0_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'hA5, 1'b1);
    check("cnt17_hdr_err", 32'(err), 32'd0);
    send_byte(8'h11, 1'b1);
    check("cnt17_err", 32'(err), 32'd1);
    check("cnt17_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'h41, 1'b1);
    tick(3);
    check("cnt_rej_q", 32'(exp_q.size()), 32'd0);

    // Full 16-entry frame fills every address without wrapping.
    payload.delete();
    for (int i = 0; i < 16; i++) payload.push_back(8'(i * 13 + 5));
    send_frame(8'h00);
    tick(3);
    check("full_done", 32'(done_cnt), 32'd3);
    check("full_err", 32'(err), 32'd0);

    // Junk before header.
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    check("junk_hold", 32'(cpu_hold), 32'd0);
    payload = '{8'h3C, 8'hFF};
    send_frame(8'h00);
    tick(3);
    check("junk_done", 32'(done_cnt), 32'd4);

    // Start-bit glitch inside a frame produces no byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    exp_q.push_back(12'h011);
    send_byte(8'h11, 1'b1);
    exp_q.push_back(12'h122);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    tick(3);
    check("glitch_done", 32'(done_cnt), 32'd5);

    // Framing error on a data byte aborts.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    exp_q.push_back(12'h041);
    send_byte(8'h41, 1'b1);
    send_byte(8'h8A, 1'b0);
    check("stop0_err", 32'(err), 32'd1);
    check("stop0_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'h99, 1'b1);
    tick(3);
    check("stop0_q", 32'(exp_q.size()), 32'd0);
    payload = '{8'h77};
    send_frame(8'h00);
    tick(3);
    check("stop0_recover", 32'(done_cnt), 32'd6);

    // load_en dropped after two of four data bytes.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    exp_q.push_back(12'h001);
    send_byte(8'h01, 1'b1);
    exp_q.push_back(12'h102);
    send_byte(8'h02, 1'b1);
    check("le_hold_before", 32'(cpu_hold), 32'd1);
    load_en = 1'b0;
    tick(1);
    check("le_hold_after", 32'(cpu_hold), 32'd0);
    send_byte(8'h03, 1'b1);
    load_en = 1'b1;
    tick(5);
    check("le_err", 32'(err), 32'd0);
    check("le_done", 32'(done_cnt), 32'd6);
    check("le_q", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    check("rst_hold_before", 32'(cpu_hold), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({mem_we, mem_addr, mem_wdata, cpu_hold, done, err}), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(60);
    payload = '{8'hAB, 8'hCD};
    send_frame(8'h00);
    tick(3);
    check("rst_recover_done", 32'(done_cnt), 32'd7);
    check("rst_recover_err", 32'(err), 32'd0);
    check("final_q", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
